hazard_stall_unit: RTL and testbench

- Pipeline hazard detector that sits in the ID stage of the 5-stage MIPS datapath.
- Produces the active-high Stall and ID/EX bubble request. Stall feeds directly into the 1-bit inverter stage that derives PCWrite and IFIDWrite (write enable = ~Stall).
- Covers load-use, branch-in-ID operand, and multi-cycle mult/div HI/LO hazards.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/muldiv_busy_tracker.sv | 52 +++++
 rtl/hazard_stall_unit.sv | 91 +++++++++
 tb/tb_hazard_stall_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   REG_IDX_W              width of a register-file index
//   REG_ZERO               index of $zero, which never creates a dependency
//   MULDIV_LATENCY_DEFAULT cycles HI/LO stays busy after a mult/div issues
//   busy_state_e           state encoding of the mult/div busy tracker
package mips_pipe_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam int unsigned MULDIV_LATENCY_DEFAULT = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } busy_state_e;

endpackage

// File: rtl/muldiv_busy_tracker.sv
// Tracks how long the multi-cycle mult/div unit keeps HI/LO invalid.
//   Clk         rising-edge clock
//   Rst         asynchronous active-low reset
//   Issue       a mult/div leaves ID this cycle
//   MulDivBusy  HI/LO result not yet valid (high for MULDIV_LATENCY cycles after issue)
module muldiv_busy_tracker
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT  // legal 1..15
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Issue,
  output logic MulDivBusy
);

  busy_state_e state_q, state_d;
  logic [3:0]  busy_cnt_q, busy_cnt_d;

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Issue) begin
          busy_cnt_d = 4'(MULDIV_LATENCY);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy_cnt_d = busy_cnt_q - 4'd1;
        if (busy_cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign MulDivBusy = (state_q == BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector for the 5-stage MIPS pipeline.
// Raises Stall (freeze PC and IF/ID) and Flush_IDEX (bubble into ID/EX)
// combinationally for load-use, branch-operand and HI/LO-busy hazards,
// and counts stalled cycles in a saturating performance counter.
//   Clk, Rst                 clock, asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_UsesRt  source operands of the instruction in ID
//   ID_IsBranch              beq/bne resolved in ID
//   ID_IsMulDiv, ID_ReadsHiLo mult/div issue, mfhi/mflo read
//   EX_RegWrite, EX_MemRead, EX_Rd  producer in EX
//   MEM_MemRead, MEM_Rd      load in MEM
//   Stall, Flush_IDEX        hazard outputs (same cycle)
//   MulDivBusy               HI/LO not yet valid
//   StallCount               stalled cycles since reset, saturating
module hazard_stall_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [REG_IDX_W-1:0]   ID_Rs,
  input  logic [REG_IDX_W-1:0]   ID_Rt,
  input  logic                   ID_UsesRt,
  input  logic                   ID_IsBranch,
  input  logic                   ID_IsMulDiv,
  input  logic                   ID_ReadsHiLo,
  input  logic                   EX_RegWrite,
  input  logic                   EX_MemRead,
  input  logic [REG_IDX_W-1:0]   EX_Rd,
  input  logic                   MEM_MemRead,
  input  logic [REG_IDX_W-1:0]   MEM_Rd,
  output logic                   Stall,
  output logic                   Flush_IDEX,
  output logic                   MulDivBusy,
  output logic [COUNT_WIDTH-1:0] StallCount
);

  logic match_ex, match_mem;
  logic load_use, br_ex, br_mem, hilo;
  logic issue;
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

  // $zero is hard-wired, so writing it never creates a dependency
  function automatic logic src_match(input logic [REG_IDX_W-1:0] r);
    return (r != REG_ZERO) && ((r == ID_Rs) || (ID_UsesRt && (r == ID_Rt)));
  endfunction

  always_comb begin
    match_ex  = src_match(EX_Rd);
    match_mem = src_match(MEM_Rd);
    load_use  = EX_MemRead && match_ex;
    br_ex     = ID_IsBranch && EX_RegWrite && match_ex;
    br_mem    = ID_IsBranch && MEM_MemRead && match_mem;
    hilo      = MulDivBusy && (ID_ReadsHiLo || ID_IsMulDiv);
    Stall     = load_use | br_ex | br_mem | hilo;
  end

  assign Flush_IDEX = Stall;

  // MulDivBusy is registered inside the tracker, so Stall -> Issue -> tracker
  // forms no combinational loop.
  assign issue = ID_IsMulDiv && !Stall;

  muldiv_busy_tracker #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_busy (
    .Clk       (Clk),
    .Rst       (Rst),
    .Issue     (issue),
    .MulDivBusy(MulDivBusy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (Stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a driver applies directed and
// random ID/EX/MEM patterns, a cycle-level reference model pushes the
// expected outputs, and a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_branch;
    logic       is_muldiv;
    logic       reads_hilo;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       mem_memread;
    logic [4:0] mem_rd;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic ID_UsesRt, ID_IsBranch, ID_IsMulDiv, ID_ReadsHiLo;
  logic EX_RegWrite, EX_MemRead, MEM_MemRead;
  logic Stall, Flush_IDEX, MulDivBusy;
  logic [31:0] StallCount;
  logic Stall_s, Flush_s, Busy_s;
  logic [3:0] StallCount_s;

  always #5 Clk = ~Clk;

  hazard_stall_unit #(.MULDIV_LATENCY(LAT), .COUNT_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .Stall(Stall), .Flush_IDEX(Flush_IDEX),
    .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  hazard_stall_unit #(.MULDIV_LATENCY(LAT), .COUNT_WIDTH(4)) dut_sat (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .Stall(Stall_s), .Flush_IDEX(Flush_s),
    .MulDivBusy(Busy_s), .StallCount(StallCount_s)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // reference model state: absolute cycle number, cycle of last mult/div issue,
  // unbounded stall total
  int          cyc = 0;
  int          issue_cyc = -100;
  longint      count = 0;
  stim_t       cur;
  bit          cur_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic bit src_match(input stim_t s, input logic [4:0] r);
    return (r != 5'd0) && ((r == s.rs) || (s.uses_rt && (r == s.rt)));
  endfunction

  function automatic bit model_stall(input stim_t s, input bit busy);
    bit load_use, br_ex, br_mem, hilo;
    load_use = s.ex_memread && src_match(s, s.ex_rd);
    br_ex    = s.is_branch && s.ex_regwrite && src_match(s, s.ex_rd);
    br_mem   = s.is_branch && s.mem_memread && src_match(s, s.mem_rd);
    hilo     = busy && (s.reads_hilo || s.is_muldiv);
    return load_use || br_ex || br_mem || hilo;
  endfunction

  function automatic stim_t nop_s();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit busy;
    @(posedge Clk);
    if (cur.rst_n) begin
      if (cur_stall) count++;
      if (cur.is_muldiv && !cur_stall) issue_cyc = cyc;
    end
    cyc++;
    #1;
    Rst = s.rst_n; ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.uses_rt;
    ID_IsBranch = s.is_branch; ID_IsMulDiv = s.is_muldiv; ID_ReadsHiLo = s.reads_hilo;
    EX_RegWrite = s.ex_regwrite; EX_MemRead = s.ex_memread; EX_Rd = s.ex_rd;
    MEM_MemRead = s.mem_memread; MEM_Rd = s.mem_rd;
    cur = s;
    if (!s.rst_n) begin
      count = 0;
      issue_cyc = -100;
    end
    busy = s.rst_n && (cyc > issue_cyc) && (cyc <= issue_cyc + int'(LAT));
    cur_stall = model_stall(s, busy);
    e.stall = cur_stall;
    e.busy  = busy;
    e.cnt32 = (count > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : count[31:0];
    e.cnt4  = (count > 15) ? 4'd15 : count[3:0];
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stall",       {31'd0, Stall},       {31'd0, mon_e.stall});
      check("flush_idex",  {31'd0, Flush_IDEX},  {31'd0, mon_e.stall});
      check("muldiv_busy", {31'd0, MulDivBusy},  {31'd0, mon_e.busy});
      check("stall_count", StallCount,           mon_e.cnt32);
      check("sat_stall",   {31'd0, Stall_s},     {31'd0, mon_e.stall});
      check("sat_count",   {28'd0, StallCount_s}, {28'd0, mon_e.cnt4});
    end
  end

  function automatic logic [4:0] pick_reg();
    int unsigned r;
    r = $urandom_range(0, 3);
    return (r == 0) ? 5'd0 : 5'(7 + r);
  endfunction

  initial begin
    stim_t s;
    cur = '0;
    Rst = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0;
    ID_IsMulDiv = 1'b0; ID_ReadsHiLo = 1'b0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
    EX_Rd = '0; MEM_MemRead = 1'b0; MEM_Rd = '0;

    // reset state
    s = '0;
    drive(s);
    drive(s);

    // load-use, then bubble
    s = nop_s(); s.ex_memread = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; drive(s);
    drive(nop_s());

    // $zero and rt filtering
    s = nop_s(); s.ex_memread = 1'b1; drive(s);
    s.ex_rd = 5'd9; s.rt = 5'd9; s.rs = 5'd1; drive(s);
    s.uses_rt = 1'b1; drive(s);

    // branch operands from EX then MEM
    s = nop_s(); s.is_branch = 1'b1; s.rs = 5'd9; s.ex_regwrite = 1'b1; s.ex_rd = 5'd9; drive(s);
    s = nop_s(); s.is_branch = 1'b1; s.rs = 5'd9; s.mem_memread = 1'b1; s.mem_rd = 5'd9; drive(s);
    s.mem_memread = 1'b0; drive(s);

    // mult then mfhi held until HI/LO valid
    s = nop_s(); s.is_muldiv = 1'b1; drive(s);
    s = nop_s(); s.reads_hilo = 1'b1;
    for (int i = 0; i < 5; i++) drive(s);
    // back-to-back mult: second one waits out the first
    s = nop_s(); s.is_muldiv = 1'b1;
    for (int i = 0; i < 6; i++) drive(s);
    for (int i = 0; i < 5; i++) drive(nop_s());

    // reset in the middle of BUSY, then mfhi proceeds
    s = nop_s(); s.is_muldiv = 1'b1; drive(s);
    s = nop_s(); s.reads_hilo = 1'b1; drive(s);
    s.rst_n = 1'b0; drive(s);
    drive(nop_s());
    s = nop_s(); s.reads_hilo = 1'b1; drive(s);
    drive(s);

    // saturation of the 4-bit counter
    s = nop_s(); s.ex_memread = 1'b1; s.ex_rd = 5'd10; s.rs = 5'd10;
    for (int i = 0; i < 20; i++) drive(s);
    drive(nop_s());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = nop_s();
      s.rst_n       = ($urandom_range(0, 199) != 0);
      s.rs          = pick_reg();
      s.rt          = pick_reg();
      s.uses_rt     = 1'($urandom_range(0, 1));
      s.is_branch   = ($urandom_range(0, 3) == 0);
      s.is_muldiv   = ($urandom_range(0, 5) == 0);
      s.reads_hilo  = ($urandom_range(0, 3) == 0);
      s.ex_regwrite = 1'($urandom_range(0, 1));
      s.ex_memread  = ($urandom_range(0, 3) == 0);
      s.ex_rd       = pick_reg();
      s.mem_memread = ($urandom_range(0, 3) == 0);
      s.mem_rd      = pick_reg();
      drive(s);
    end
    drive(nop_s());

    repeat (2) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
